// File: rtl/xy_input_conditioner_pkg.sv
// Shared types for the xy input conditioner.
// Pair FSM encoding and synchroniser depth.
package xy_cond_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } pair_state_e;

endpackage

// File: rtl/xy_input_conditioner_if.sv
// Event bundle from the input conditioner to the x/y FSM.
// master drives events and levels, slave consumes them.
interface xy_input_conditioner_if;

    logic o_x;
    logic o_y;
    logic o_step;
    logic o_x_lvl;
    logic o_y_lvl;
    logic o_pending;

    modport master (
        output o_x, o_y, o_step,
        output o_x_lvl, o_y_lvl, o_pending
    );

    modport slave (
        input o_x, o_y, o_step,
        input o_x_lvl, o_y_lvl, o_pending
    );

endinterface

// File: rtl/xy_input_conditioner_btn_debounce.sv
// Synchronise, debounce and edge-detect one active-low button.
// XY_AUTOREPEAT_EN adds a held-button repeat pulse.
module btn_debounce
    import xy_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W = 16
`ifdef XY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 25000000
`endif
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw_n,
    output logic o_lvl,
    output logic o_press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic sample;
    logic lvl_q;
    logic lvl_d1;
    logic rise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw_n};
        end
    end

    assign sample = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            lvl_d1 <= 1'b0;
        end else begin
            lvl_d1 <= lvl_q;
            if (sample == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q <= '0;
                lvl_q <= ~lvl_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign rise  = lvl_q & ~lvl_d1;
    assign o_lvl = lvl_q;

`ifdef XY_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] rep_q;
    logic rep_hit;

    // Runs 1..REPEAT_CYCLES so the first repeat lands a full period after the press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_q <= '0;
        end else if (!lvl_q) begin
            rep_q <= '0;
        end else if (rep_q == RW'(REPEAT_CYCLES)) begin
            rep_q <= RW'(1);
        end else begin
            rep_q <= rep_q + 1'b1;
        end
    end

    assign rep_hit = lvl_q && (rep_q == RW'(REPEAT_CYCLES));
    assign o_press = rise | rep_hit;
`else
    assign o_press = rise;
`endif

endmodule

// File: rtl/xy_input_conditioner.sv
// Button pair merger: two debounced presses -> one x/y step event.
// Define XY_AUTOREPEAT_EN to re-issue presses while a button is held.
module xy_input_conditioner
    import xy_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PAIR_CYCLES = 2500,
    parameter int CNT_W = 16
`ifdef XY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 25000000
`endif
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_x_n,
    input  logic i_btn_y_n,
    xy_input_conditioner_if.master evt
);

    pair_state_e state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic lx_q, lx_d;
    logic ly_q, ly_d;
    logic x_lvl, y_lvl;
    logic px, py;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W(CNT_W)
`ifdef XY_AUTOREPEAT_EN
        ,
        .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_db_x (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_raw_n(i_btn_x_n),
        .o_lvl(x_lvl),
        .o_press(px)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W(CNT_W)
`ifdef XY_AUTOREPEAT_EN
        ,
        .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_db_y (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_raw_n(i_btn_y_n),
        .o_lvl(y_lvl),
        .o_press(py)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            lx_q    <= 1'b0;
            ly_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        unique case (1'b1)
            state_q == IDLE: begin
                if (px && py) begin
                    state_d = EMIT;
                    lx_d    = 1'b1;
                    ly_d    = 1'b1;
                end else if (px || py) begin
                    state_d = WAIT;
                    lx_d    = px;
                    ly_d    = py;
                    pcnt_d  = '0;
                end
            end
            state_q == WAIT: begin
                // Only the not-yet-latched button can close the window early.
                if ((px && !lx_q) || (py && !ly_q)) begin
                    state_d = EMIT;
                    lx_d    = 1'b1;
                    ly_d    = 1'b1;
                end else if (pcnt_q == CNT_W'(PAIR_CYCLES - 1)) begin
                    state_d = EMIT;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            state_q == EMIT: begin
                state_d = IDLE;
                pcnt_d  = '0;
                lx_d    = 1'b0;
                ly_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
                pcnt_d  = '0;
                lx_d    = 1'b0;
                ly_d    = 1'b0;
            end
        endcase
    end

    assign evt.o_step    = (state_q == EMIT);
    assign evt.o_x       = (state_q == EMIT) & lx_q;
    assign evt.o_y       = (state_q == EMIT) & ly_q;
    assign evt.o_pending = (state_q == WAIT);
    assign evt.o_x_lvl   = x_lvl;
    assign evt.o_y_lvl   = y_lvl;

endmodule

// File: doc/xy_input_conditioner.md
Name: xy_input_conditioner

Overview:
- Upstream stage of the lab-six x/y-driven state machine.
- Takes two raw active-low push-buttons (board KEYs) and synchronises and debounces each one.
- Merges near-simultaneous presses and emits one single-cycle event carrying the x and y values, plus a step strobe.
- The downstream FSM advances only on o_step, so one physical press gives exactly one state transition.

Parameters:
- DEBOUNCE_CYCLES, 50000: input must be stable for this many consecutive i_clk cycles before the debounced level changes (1 ms at 50 MHz).
- PAIR_CYCLES, 2500: after the first accepted press, window in cycles during which a press on the other button merges into the same event.
- CNT_W, 16: width of the debounce and pair counters; must hold max(DEBOUNCE_CYCLES, PAIR_CYCLES).
- REPEAT_CYCLES, 25000000: auto-repeat period (used only with the optional feature).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_btn_x_n  in  1  raw x button, active-low, asynchronous to i_clk
- i_btn_y_n  in  1  raw y button, active-low, asynchronous to i_clk
- o_x  out  1  x value of the current event; valid only while o_step=1, else 0
- o_y  out  1  y value of the current event; valid only while o_step=1, else 0
- o_step  out  1  one-cycle event strobe
- o_x_lvl  out  1  debounced x level, 1 = pressed
- o_y_lvl  out  1  debounced y level, 1 = pressed
- o_pending  out  1  high while the pair window is open

Behaviour:
- Interface fixed: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0, all counters 0, pair FSM in IDLE, synchroniser flops 1 (released).
- Synchronisation: each raw input passes through 2 flops, then is inverted to active-high.
- Debounce, per input:
  - Counter clears whenever the synced sample equals the current debounced level.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 the level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
  - A rising edge of the debounced level produces a one-cycle internal press pulse (px or py).
- Pair FSM, 3 states:
  - IDLE:
    - px and py in the same cycle -> EMIT with x=1, y=1.
    - Only one press -> WAIT; latch that bit; pair counter=0.
  - WAIT (o_pending=1):
    - Press of the other button -> EMIT with both bits set.
    - Repeat press of the same button is ignored.
    - Pair counter reaches PAIR_CYCLES-1 -> EMIT with the latched bit only.
  - EMIT: o_step=1 with o_x/o_y for exactly one cycle, then -> IDLE with latches cleared. Presses arriving in the EMIT cycle are dropped.
- Latency: synchroniser 2 cycles + DEBOUNCE_CYCLES, then either PAIR_CYCLES (single press) or 1 cycle (merged/simultaneous press) to o_step.
- Releases never generate events. Holding a button produces exactly one event.
- Reset asserted mid-window: event discarded, no o_step after reset release. A button held through reset release is debounced as a new press.
- o_x=o_y=0 with o_step=1 is impossible.

Optional Feature:
- Macro: XY_AUTOREPEAT_EN.
- Defined:
  - While a debounced level stays high, a per-input repeat counter re-issues that input's press pulse every REPEAT_CYCLES cycles after the initial press.
  - Repeats go through the pair FSM like normal presses.
  - The counter clears on release and on reset.
- Undefined: no repeat counters; one event per press.

Decomposition:
- Package xy_cond_pkg:
  - pair FSM state typedef: IDLE=2'd0, WAIT=2'd1, EMIT=2'd2
  - SYNC_STAGES=2 localparam
- Sub-module btn_debounce, instantiated twice:
  - contains synchroniser, debounce counter, level, and press pulse (plus the repeat counter when XY_AUTOREPEAT_EN is defined)
  - ports: i_clk, i_rst_n, i_raw_n, o_lvl, o_press
- The top level holds only the pair FSM and output registers.

Test Plan (sim params DEBOUNCE_CYCLES=4, PAIR_CYCLES=3, REPEAT_CYCLES=10):
- Hold x low for 10 cycles, y released -> o_x_lvl=1; exactly one o_step with x=1,y=0; o_pending high for 3 cycles before it.
- x bounces as 2 cycles low, 1 high, 2 low, 1 high -> o_x_lvl stays 0; no o_step.
- x pressed, y pressed 1 cycle later (both held) -> single o_step with x=1,y=1; o_pending low afterwards.
- x and y pressed on the same edge -> o_step one cycle after both press pulses, x=1,y=1; o_pending never asserts.
- x press accepted, i_rst_n pulled low during WAIT, then released with x still held -> no event from the aborted window; one fresh event x=1,y=0 after re-debounce.
- XY_AUTOREPEAT_EN defined, y held 40 cycles -> o_step with y=1 at the initial press plus every 10 cycles (3 further events); undefined -> exactly 1 event.
